// File: rtl/player_motion_ctrl.sv
// Per-frame player state engine: rotation, movement and per-axis wall checks.
// Map-read collision is enabled by defining PLAYER_MOTION_COLLISION_EN; otherwise only bounds apply.
module player_motion_ctrl #(
    parameter int unsigned N           = 24,
    parameter int unsigned INT_BITS    = 8,
    parameter int unsigned FRAC_BITS   = 8,
    parameter int unsigned MAP_WIDTH   = 8,
    parameter int unsigned MAP_LATENCY = 2,
    parameter logic [INT_BITS+FRAC_BITS-1:0] COS_ROT    = 16'h00FC,
    parameter logic [INT_BITS+FRAC_BITS-1:0] SIN_ROT    = 16'h002C,
    parameter logic [INT_BITS+FRAC_BITS-1:0] MOVE_SPEED = 16'h0040,
    parameter logic [INT_BITS+FRAC_BITS-1:0] START_X    = 16'h0C80,
    parameter logic [INT_BITS+FRAC_BITS-1:0] START_Y    = 16'h0C80,
    parameter logic [INT_BITS+FRAC_BITS-1:0] PLANE_MAG  = 16'h00A9
) (
    input  logic                               pixel_clk_in,
    input  logic                               rst_n_in,
    input  logic                               frame_tick_in,
    input  logic [1:0]                         move_dir_in,
    input  logic [1:0]                         rot_dir_in,
    output logic [$clog2(N*N)-1:0]             map_addr_out,
    output logic                               map_rd_en_out,
    input  logic [MAP_WIDTH-1:0]               map_data_in,
    output logic [INT_BITS+FRAC_BITS-1:0]      pos_x_out,
    output logic [INT_BITS+FRAC_BITS-1:0]      pos_y_out,
    output logic [INT_BITS+FRAC_BITS-1:0]      dir_x_out,
    output logic [INT_BITS+FRAC_BITS-1:0]      dir_y_out,
    output logic [INT_BITS+FRAC_BITS-1:0]      plane_x_out,
    output logic [INT_BITS+FRAC_BITS-1:0]      plane_y_out,
    output logic                               busy_out,
    output logic                               update_done_out
);
    localparam int unsigned W  = INT_BITS + FRAC_BITS;
    localparam int unsigned AW = $clog2(N*N);
    localparam int unsigned PW = 2*W + 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ROTATE    = 3'd1;
    localparam logic [2:0] S_MOVE_CALC = 3'd2;
    localparam logic [2:0] S_RD_X      = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd7;
`ifdef PLAYER_MOTION_COLLISION_EN
    localparam logic [2:0] S_WAIT_X    = 3'd4;
    localparam logic [2:0] S_RD_Y      = 3'd5;
    localparam logic [2:0] S_WAIT_Y    = 3'd6;
    localparam int unsigned CW = $clog2(MAP_LATENCY + 1);
`endif

    function automatic logic signed [PW-1:0] mul(input logic signed [W-1:0] a,
                                                 input logic signed [W-1:0] b);
        return PW'(a) * PW'(b);
    endfunction

    // Round half up, then arithmetic shift back to W bits.
    function automatic logic signed [W-1:0] rnd(input logic signed [PW-1:0] v);
        logic signed [PW-1:0] t;
        t = v + PW'(1 << (FRAC_BITS - 1));
        t = t >>> FRAC_BITS;
        return t[W-1:0];
    endfunction

    function automatic logic [2*W-1:0] rotate(input logic signed [W-1:0] x,
                                              input logic signed [W-1:0] y,
                                              input logic                left);
        logic signed [PW-1:0] xc, xs, yc, ys;
        xc = mul(x, $signed(COS_ROT));
        xs = mul(x, $signed(SIN_ROT));
        yc = mul(y, $signed(COS_ROT));
        ys = mul(y, $signed(SIN_ROT));
        if (left) return {rnd(xc - ys), rnd(xs + yc)};
        return {rnd(xc + ys), rnd(yc - xs)};
    endfunction

    function automatic logic signed [W-1:0] step(input logic signed [W-1:0] d, input logic fwd);
        logic signed [PW-1:0] p;
        p = mul(d, $signed(MOVE_SPEED));
        return fwd ? rnd(p) : rnd(-p);
    endfunction

    function automatic logic in_bounds(input logic signed [W-1:0] c);
        return !c[W-1] && (32'(c[W-1:FRAC_BITS]) < N);
    endfunction

    logic [2:0]          state_q, state_d;
    logic [1:0]          mv_q, mv_d, rt_q, rt_d;
    logic signed [W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic signed [W-1:0] dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic signed [W-1:0] plane_x_q, plane_x_d, plane_y_q, plane_y_d;
    logic signed [W-1:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic [2*W-1:0]      dir_rot_c, plane_rot_c;
    logic signed [W-1:0] cand_x_c, cand_y_c;

    assign dir_rot_c   = rotate(dir_x_q, dir_y_q, rt_q[1]);
    assign plane_rot_c = rotate(plane_x_q, plane_y_q, rt_q[1]);
    assign cand_x_c    = pos_x_q + step(dir_x_q, mv_q[1]);
    assign cand_y_c    = pos_y_q + step(dir_y_q, mv_q[1]);

`ifdef PLAYER_MOTION_COLLISION_EN
    function automatic logic [AW-1:0] cell_addr(input logic signed [W-1:0] x,
                                                input logic signed [W-1:0] y);
        return AW'(32'(y[W-1:FRAC_BITS]) * N + 32'(x[W-1:FRAC_BITS]));
    endfunction

    logic                rd_en_q, rd_en_d, ok_q, ok_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic signed [W-1:0] new_x_c;

    // X axis result feeds the Y probe so the player slides along walls.
    assign new_x_c       = (ok_q && map_data_in == '0) ? cand_x_q : pos_x_q;
    assign map_rd_en_out = rd_en_q;
    assign map_addr_out  = addr_q;
`else
    localparam int unsigned MAP_LATENCY_UNUSED = MAP_LATENCY;
    logic map_data_unused;
    assign map_data_unused = ^map_data_in;
    assign map_rd_en_out   = 1'b0;
    assign map_addr_out    = '0;
`endif

    always_comb begin
        state_d   = state_q;
        mv_d      = mv_q;
        rt_d      = rt_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        dir_x_d   = dir_x_q;
        dir_y_d   = dir_y_q;
        plane_x_d = plane_x_q;
        plane_y_d = plane_y_q;
        cand_x_d  = cand_x_q;
        cand_y_d  = cand_y_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef PLAYER_MOTION_COLLISION_EN
        rd_en_d   = 1'b0;
        ok_d      = ok_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (done_q) busy_d = 1'b0;
                if (frame_tick_in && !busy_q) begin
                    mv_d   = move_dir_in;
                    rt_d   = rot_dir_in;
                    busy_d = 1'b1;
                    if (^rot_dir_in)       state_d = S_ROTATE;
                    else if (^move_dir_in) state_d = S_MOVE_CALC;
                    else                   state_d = S_DONE;
                end
            end
            S_ROTATE: begin
                {dir_x_d, dir_y_d}     = dir_rot_c;
                {plane_x_d, plane_y_d} = plane_rot_c;
                state_d = (^mv_q) ? S_MOVE_CALC : S_DONE;
            end
            S_MOVE_CALC: begin
                cand_x_d = cand_x_c;
                cand_y_d = cand_y_c;
`ifdef PLAYER_MOTION_COLLISION_EN
                ok_d    = in_bounds(cand_x_c);
                rd_en_d = in_bounds(cand_x_c);
                if (in_bounds(cand_x_c)) addr_d = cell_addr(cand_x_c, pos_y_q);
`endif
                state_d = S_RD_X;
            end
`ifdef PLAYER_MOTION_COLLISION_EN
            S_RD_X: begin
                cnt_d   = CW'(MAP_LATENCY - 1);
                state_d = S_WAIT_X;
            end
            S_WAIT_X: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    pos_x_d = new_x_c;
                    ok_d    = in_bounds(cand_y_q);
                    rd_en_d = in_bounds(cand_y_q);
                    if (in_bounds(cand_y_q)) addr_d = cell_addr(new_x_c, cand_y_q);
                    state_d = S_RD_Y;
                end
            end
            S_RD_Y: begin
                cnt_d   = CW'(MAP_LATENCY - 1);
                state_d = S_WAIT_Y;
            end
            S_WAIT_Y: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    if (ok_q && map_data_in == '0) pos_y_d = cand_y_q;
                    state_d = S_DONE;
                end
            end
`else
            // Single commit cycle stands in for the skipped map round trips.
            S_RD_X: begin
                if (in_bounds(cand_x_q)) pos_x_d = cand_x_q;
                if (in_bounds(cand_y_q)) pos_y_d = cand_y_q;
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= S_IDLE;
            mv_q      <= '0;
            rt_q      <= '0;
            pos_x_q   <= $signed(START_X);
            pos_y_q   <= $signed(START_Y);
            dir_x_q   <= '0;
            dir_y_q   <= W'(1 << FRAC_BITS);
            plane_x_q <= $signed(PLANE_MAG);
            plane_y_q <= '0;
            cand_x_q  <= '0;
            cand_y_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef PLAYER_MOTION_COLLISION_EN
            rd_en_q   <= 1'b0;
            ok_q      <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            mv_q      <= mv_d;
            rt_q      <= rt_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
            plane_x_q <= plane_x_d;
            plane_y_q <= plane_y_d;
            cand_x_q  <= cand_x_d;
            cand_y_q  <= cand_y_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef PLAYER_MOTION_COLLISION_EN
            rd_en_q   <= rd_en_d;
            ok_q      <= ok_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign pos_x_out       = pos_x_q;
    assign pos_y_out       = pos_y_q;
    assign dir_x_out       = dir_x_q;
    assign dir_y_out       = dir_y_q;
    assign plane_x_out     = plane_x_q;
    assign plane_y_out     = plane_y_q;
    assign busy_out        = busy_q;
    assign update_done_out = done_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl with a latency-accurate map ROM model.
// Expectations cover both builds (PLAYER_MOTION_COLLISION_EN defined or not).
module tb_player_motion_ctrl;
    localparam int unsigned L = 2;
`ifdef PLAYER_MOTION_COLLISION_EN
    localparam bit COLL = 1'b1;
`else
    localparam bit COLL = 1'b0;
`endif
    localparam int MOVE_LAT = COLL ? 4 + 2*L : 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic [1:0]  mv, rt;
    logic [9:0]  addr;
    logic        rd_en;
    logic [7:0]  mdata;
    logic [15:0] px, py, dx, dy, plx, ply;
    logic        busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    player_motion_ctrl dut (
        .pixel_clk_in    (clk),
        .rst_n_in        (rst_n),
        .frame_tick_in   (tick),
        .move_dir_in     (mv),
        .rot_dir_in      (rt),
        .map_addr_out    (addr),
        .map_rd_en_out   (rd_en),
        .map_data_in     (mdata),
        .pos_x_out       (px),
        .pos_y_out       (py),
        .dir_x_out       (dx),
        .dir_y_out       (dy),
        .plane_x_out     (plx),
        .plane_y_out     (ply),
        .busy_out        (busy),
        .update_done_out (done)
    );

    // Map ROM: data for a strobe is valid L cycles later; garbage otherwise.
    logic [7:0] mem  [0:1023];
    logic [7:0] pipe [0:L-1];
    logic [9:0] rd_log [0:255] = '{default: '0};
    int         n_rd = 0;

    always @(posedge clk) begin
        pipe[0] <= rd_en ? mem[addr] : 8'hEE;
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        if (rd_en) begin
            rd_log[n_rd % 256] <= addr;
            n_rd <= n_rd + 1;
        end
    end
    assign mdata = pipe[L-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_tick(input logic [1:0] m, input logic [1:0] r,
                           output int lat, output int reads, output int base, output logic bsy);
        @(negedge clk);
        mv = m; rt = r; tick = 1'b1; base = n_rd;
        @(negedge clk);
        tick = 1'b0; lat = -1; bsy = busy;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        reads = n_rd - base;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_px"}, 32'(px), 32'h0C80);
        check({tag, "_py"}, 32'(py), 32'h0C80);
        check({tag, "_dx"}, 32'(dx), 32'h0000);
        check({tag, "_dy"}, 32'(dy), 32'h0100);
        check({tag, "_plx"}, 32'(plx), 32'h00A9);
        check({tag, "_ply"}, 32'(ply), 32'h0000);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_rden"}, 32'(rd_en), 32'h0);
        check({tag, "_addr"}, 32'(addr), 32'h0);
    endtask

    int   lat, reads, base, pulses;
    logic bsy;
    logic [15:0] py_prev;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        rst_n = 1'b0; tick = 1'b0; mv = 2'b00; rt = 2'b00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");

        // Rotate left from the reset pose.
        do_tick(2'b00, 2'b10, lat, reads, base, bsy);
        check("rotl_lat", 32'(lat), 32'd2);
        check("rotl_busy", 32'(bsy), 32'h1);
        check("rotl_reads", 32'(reads), 32'd0);
        check("rotl_dx", 32'(dx), 32'hFFD4);
        check("rotl_dy", 32'(dy), 32'h00FC);
        check("rotl_plx", 32'(plx), 32'h00A6);
        check("rotl_ply", 32'(ply), 32'h001D);
        check("rotl_px", 32'(px), 32'h0C80);

        // Rotate right: dir returns exactly, plane picks up rounding loss.
        do_tick(2'b00, 2'b01, lat, reads, base, bsy);
        check("rotr_lat", 32'(lat), 32'd2);
        check("rotr_dx", 32'(dx), 32'h0000);
        check("rotr_dy", 32'(dy), 32'h0100);
        check("rotr_plx", 32'(plx), 32'h00A8);
        check("rotr_ply", 32'(ply), 32'h0000);

        // Forward over an empty map.
        do_tick(2'b10, 2'b00, lat, reads, base, bsy);
        check("fwd_lat", 32'(lat), 32'(MOVE_LAT));
        check("fwd_reads", 32'(reads), COLL ? 32'd2 : 32'd0);
        check("fwd_addr0", 32'(rd_log[base % 256]), COLL ? 32'd300 : 32'd0);
        check("fwd_addr1", 32'(rd_log[(base + 1) % 256]), COLL ? 32'd300 : 32'd0);
        check("fwd_py", 32'(py), 32'h0CC0);
        check("fwd_px", 32'(px), 32'h0C80);

        // Wall at cell (12,13) blocks the Y axis only when map checks are on.
        mem[324] = 8'h01;
        do_tick(2'b10, 2'b00, lat, reads, base, bsy);
        mem[324] = 8'h00;
        check("wall_lat", 32'(lat), 32'(MOVE_LAT));
        check("wall_reads", 32'(reads), COLL ? 32'd2 : 32'd0);
        check("wall_addr0", 32'(rd_log[base % 256]), COLL ? 32'd300 : 32'd0);
        check("wall_addr1", 32'(rd_log[(base + 1) % 256]), COLL ? 32'd324 : 32'd0);
        check("wall_py", 32'(py), COLL ? 32'h0CC0 : 32'h0D00);
        check("wall_px", 32'(px), 32'h0C80);
        py_prev = py;

        // Both move bits set is a no-op; ticks held while busy must be dropped.
        @(negedge clk);
        mv = 2'b11; rt = 2'b00; tick = 1'b1; base = n_rd;
        @(negedge clk);
        mv = 2'b10;
        @(negedge clk);
        check("noop_done_k1", 32'(done), 32'h1);
        @(negedge clk);
        tick = 1'b0;
        pulses = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("noop_pulses", 32'(pulses), 32'd1);
        check("noop_reads", 32'(n_rd - base), 32'd0);
        check("noop_py", 32'(py), 32'(py_prev));
        check("noop_busy", 32'(busy), 32'h0);

        // Rotate left then move with the rotated direction.
        do_tick(2'b10, 2'b10, lat, reads, base, bsy);
        check("rotmv_lat", 32'(lat), 32'(MOVE_LAT + 1));
        check("rotmv_reads", 32'(reads), COLL ? 32'd2 : 32'd0);
        check("rotmv_dx", 32'(dx), 32'hFFD4);
        check("rotmv_px", 32'(px), 32'h0C75);
        check("rotmv_py", 32'(py), COLL ? 32'h0CFF : 32'h0D3F);

        // Reset asserted while the update is in flight.
        @(negedge clk);
        mv = 2'b10; rt = 2'b00; tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("midrst_nopulse", 32'(pulses), 32'd0);
        do_tick(2'b10, 2'b00, lat, reads, base, bsy);
        check("postrst_lat", 32'(lat), 32'(MOVE_LAT));
        check("postrst_addr1", 32'(rd_log[(base + 1) % 256]), COLL ? 32'd300 : 32'd0);
        check("postrst_py", 32'(py), 32'h0CC0);

        // Walk to the last in-bounds step, then push against the map edge.
        for (int i = 0; i < 44; i++) do_tick(2'b10, 2'b00, lat, reads, base, bsy);
        check("edge_py", 32'(py), 32'h17C0);
        do_tick(2'b10, 2'b00, lat, reads, base, bsy);
        check("oob_lat", 32'(lat), 32'(MOVE_LAT));
        check("oob_reads", 32'(reads), COLL ? 32'd1 : 32'd0);
        check("oob_addr0", 32'(rd_log[base % 256]), COLL ? 32'd564 : 32'd0);
        check("oob_py", 32'(py), 32'h17C0);
        check("oob_px", 32'(px), 32'h0C80);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/player_motion_ctrl.md
Name: player_motion_ctrl

Overview:
- Per-frame player state engine for the raycaster. Holds player position, direction vector and camera-plane vector in signed fixed point.
- On each frame tick it samples the move and rotate buttons, then applies rotation and movement.
- Movement is collision-checked per axis against the world-map BRAM through an external read port, which allows wall sliding.
- The outputs feed the ray-casting pipeline and stay stable between updates.

Parameters:
- N, 24, map is N x N cells; map address = cell_y*N + cell_x.
- INT_BITS, 8, integer bits of every fixed-point value (includes the sign bit).
- FRAC_BITS, 8, fraction bits; W = INT_BITS+FRAC_BITS.
- MAP_WIDTH, 8, map cell width; a value of 0 means empty.
- MAP_LATENCY, 2, cycles from the map_rd_en cycle to valid map_data_in (1..4).
- COS_ROT, 16'h00FC, cos of the rotation step (Q8.8).
- SIN_ROT, 16'h002C, sin of the rotation step (Q8.8).
- MOVE_SPEED, 16'h0040, step length per update (0.25 cell).
- START_X, 16'h0C80, reset X position (12.5).
- START_Y, 16'h0C80, reset Y position (12.5).
- PLANE_MAG, 16'h00A9, reset plane length (0.66).

Ports:
- pixel_clk_in, in, 1, the only clock.
- rst_n_in, in, 1, asynchronous active-low reset.
- frame_tick_in, in, 1, one-cycle pulse requesting one update.
- move_dir_in, in, 2, [1]=forward, [0]=back.
- rot_dir_in, in, 2, [1]=left, [0]=right.
- map_addr_out, out, $clog2(N*N), map read address.
- map_rd_en_out, out, 1, one-cycle read strobe.
- map_data_in, in, MAP_WIDTH, map read data.
- pos_x_out, pos_y_out, out, W each, signed position.
- dir_x_out, dir_y_out, out, W each, signed direction.
- plane_x_out, plane_y_out, out, W each, signed camera plane.
- busy_out, out, 1, high while an update is in progress.
- update_done_out, out, 1, one-cycle pulse when the update completes.

Behaviour:
- Reset (asynchronous, takes effect mid-operation too):
  - FSM goes to IDLE and any pending update is discarded.
  - pos = (START_X, START_Y); dir = (0, 1<<FRAC_BITS); plane = (PLANE_MAG, 0).
  - busy_out, update_done_out, map_rd_en_out and map_addr_out are all 0.
- FSM states: IDLE, ROTATE, MOVE_CALC, RD_X, WAIT_X, RD_Y, WAIT_Y, DONE.
- IDLE:
  - When frame_tick_in is high at edge k, latch the buttons and set busy_out=1.
  - Next state: ROTATE if exactly one rot bit is set; else MOVE_CALC if exactly one move bit is set; else DONE.
  - Both bits of a pair set means no action for that pair.
- Ticks arriving while busy_out=1 are ignored (dropped, not queued).
- ROTATE (1 cycle) updates dir and plane together.
  - Left: x' = x*C - y*S; y' = x*S + y*C.
  - Right: x' = x*C + y*S; y' = -x*S + y*C.
  - Next state: MOVE_CALC if a move is pending, else DONE. Movement always uses the rotated dir.
- Fixed-point arithmetic:
  - Products are full 2W signed; sums are 2W+1 bits.
  - Round by adding 1<<(FRAC_BITS-1), then arithmetic shift right by FRAC_BITS, then truncate to W bits.
- MOVE_CALC:
  - Forward: step = +dir*MOVE_SPEED (rounded as above).
  - Back: step = -dir*MOVE_SPEED.
  - candX = pos_x+step_x, candY = pos_y+step_y.
- Axis checks:
  - RD_X checks cell (candX>>FRAC_BITS, pos_y>>FRAC_BITS).
  - RD_Y checks cell (new_x>>FRAC_BITS, candY>>FRAC_BITS), where new_x is the result of the X check.
  - In each RD state, map_rd_en_out is high for 1 cycle with the address.
  - WAIT holds for MAP_LATENCY cycles, then samples map_data_in. A value of 0 accepts the axis; nonzero keeps the old coordinate.
- Out-of-bounds candidates:
  - Negative, or cell index >= N, counts as a wall.
  - No read is issued; the state still spends the RD cycle plus MAP_LATENCY cycles so timing stays fixed.
- Output timing:
  - Outputs change only at the ROTATE exit (dir, plane) and at each WAIT exit (pos); never otherwise.
- DONE:
  - update_done_out=1 for one cycle, busy_out=0 on the following cycle, then IDLE.
- Latency from the tick edge k to the update_done_out cycle:
  - No-op: k+1.
  - Rotate only: k+2.
  - Move only: k+2+2*(MAP_LATENCY+1).
  - Rotate+move: one more cycle than move only.

Optional Feature:
- Macro: PLAYER_MOTION_COLLISION_EN.
- Defined: per-axis map checks are performed as described above.
- Undefined:
  - No map reads are performed; map_rd_en_out and map_addr_out are tied to 0.
  - Only the bounds check applies.
  - RD/WAIT states are skipped; a move completes at k+3 (k+4 with rotation).

Test Plan:
- Reset released, no ticks -> pos=(0x0C80,0x0C80), dir=(0x0000,0x0100), plane=(0x00A9,0x0000); busy_out=0.
- Tick with forward, empty map, MAP_LATENCY=2 -> addresses 300 then 300; pos_y=0x0CC0, pos_x unchanged; update_done_out asserted at k+8.
- Tick with rotate left only -> dir=(0xFFD4,0x00FC), plane=(0x00A6,0x001D); update_done_out at k+2; no map read issued.
- pos_y=0x0CE0, cell(12,13) nonzero, forward tick -> second read address 324; pos_y stays 0x0CE0; pos_x unchanged.
- Forward and back both set, plus a tick -> no read; update_done_out at k+1; all outputs unchanged. A second tick during busy is dropped (exactly one done pulse).
- rst_n_in low during WAIT_X -> outputs return to reset values immediately; map_rd_en_out=0; after release the next tick behaves normally.
